// File: rtl/controle_voltas.sv
// controle_voltas: stopwatch lap controller driving a 4-entry external lap memory.
// Optional build macro LAP_OVERWRITE_EN: a save while full overwrites the oldest lap.
module controle_voltas #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  save_pulse,
  input  logic                  next_pulse,
  input  logic                  clear_pulse,
  input  logic [DATA_WIDTH-1:0] time_in,
  output logic                  mem_write_enable,
  output logic [1:0]            mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [1:0]            mem_read_address,
  output logic [2:0]            lap_count,
  output logic                  full,
  output logic                  busy
);

`ifdef LAP_OVERWRITE_EN
  localparam bit OVERWRITE_EN = 1'b1;
`else
  localparam bit OVERWRITE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            clr_cnt_q, clr_cnt_d;
  logic [2:0]            lap_count_q, lap_count_d;
  logic [DATA_WIDTH-1:0] capture_q, capture_d;
  logic                  init_pending_q, init_pending_d;

  logic       full_w;
  logic [2:0] rd_inc;
  logic [1:0] rd_next;

  assign full_w  = (lap_count_q == 3'd4);
  // Step to the next valid lap, wrapping at the number of laps held.
  assign rd_inc  = {1'b0, rd_ptr_q} + 3'd1;
  assign rd_next = (rd_inc >= lap_count_q) ? 2'd0 : rd_inc[1:0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    clr_cnt_d      = clr_cnt_q;
    lap_count_d    = lap_count_q;
    capture_d      = capture_q;
    init_pending_d = init_pending_q;

    unique case (state_q)
      IDLE: begin
        if (init_pending_q || clear_pulse) begin
          state_d        = CLEAR;
          clr_cnt_d      = 2'd0;
          init_pending_d = 1'b0;
        end else if (save_pulse) begin
          // A save that loses to a full memory still blocks a simultaneous next.
          if (!full_w || OVERWRITE_EN) begin
            capture_d = time_in;
            state_d   = WRITE;
          end
        end else if (next_pulse) begin
          if (lap_count_q != 3'd0) rd_ptr_d = rd_next;
        end
      end

      WRITE: begin
        wr_ptr_d    = wr_ptr_q + 2'd1;
        lap_count_d = full_w ? 3'd4 : lap_count_q + 3'd1;
        rd_ptr_d    = wr_ptr_q;
        state_d     = IDLE;
      end

      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 2'd1;
        if (clr_cnt_q == 2'd3) begin
          wr_ptr_d    = 2'd0;
          rd_ptr_d    = 2'd0;
          lap_count_d = 3'd0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= 2'd0;
      rd_ptr_q       <= 2'd0;
      clr_cnt_q      <= 2'd0;
      lap_count_q    <= 3'd0;
      capture_q      <= '0;
      init_pending_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      clr_cnt_q      <= clr_cnt_d;
      lap_count_q    <= lap_count_d;
      capture_q      <= capture_d;
      init_pending_q <= init_pending_d;
    end
  end

  // Memory port decodes from registered state only, so reset drops the strobe at once.
  always_comb begin
    mem_write_enable  = 1'b0;
    mem_write_address = 2'd0;
    mem_data_in       = '0;
    unique case (state_q)
      WRITE: begin
        mem_write_enable  = 1'b1;
        mem_write_address = wr_ptr_q;
        mem_data_in       = capture_q;
      end
      CLEAR: begin
        mem_write_enable  = 1'b1;
        mem_write_address = clr_cnt_q;
      end
      default: ;
    endcase
  end

  assign busy             = (state_q != IDLE);
  assign full             = full_w;
  assign lap_count        = lap_count_q;
  assign mem_read_address = rd_ptr_q;

endmodule

// File: doc/controle_voltas.md
CONTROLE_VOLTAS -- requirements
Module: controle_voltas

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one stored BCD lap time.
REQ-002 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port save_pulse  input  1  one-cycle request to store the current time as a lap.
REQ-005 SHALL have port next_pulse  input  1  one-cycle request to show the next stored lap.
REQ-006 SHALL have port clear_pulse  input  1  one-cycle request to erase all laps.
REQ-007 SHALL have port time_in  input  DATA_WIDTH  live stopwatch time, BCD.
REQ-008 SHALL have port mem_write_enable  output  1  write strobe to the 4-entry lap memory.
REQ-009 SHALL have port mem_write_address  output  2  memory write address.
REQ-010 SHALL have port mem_data_in  output  DATA_WIDTH  memory write data.
REQ-011 SHALL have port mem_read_address  output  2  memory read address (lap on display).
REQ-012 SHALL have port lap_count  output  3  number of valid laps, 0..4.
REQ-013 SHALL have port full  output  1  high when lap_count == 4.
REQ-014 SHALL have port busy  output  1  high in WRITE and CLEAR states.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, CLEAR; outputs decode from registered state only.
REQ-016 IDLE: mem_write_enable=0; requests are sampled only in IDLE, and pulses arriving while busy=1 SHALL be dropped.
REQ-017 Simultaneous requests in IDLE SHALL be resolved by priority clear > save > next; losers are dropped.
REQ-018 Save accepted at edge N SHALL latch time_in into a capture register and enter WRITE; during cycle N+1, mem_write_enable=1, mem_write_address=wr_ptr, mem_data_in=captured value.
REQ-019 On leaving WRITE (one cycle), wr_ptr SHALL advance modulo 4, lap_count SHALL increment saturating at 4, mem_read_address SHALL become the address just written, and the FSM SHALL return to IDLE.
REQ-020 Save with full=1 SHALL follow the Configuration section.
REQ-021 Next accepted with lap_count=0 SHALL leave mem_read_address unchanged.
REQ-022 Next accepted with lap_count=k>0 SHALL set mem_read_address to (mem_read_address+1) mod k when k<4, or mod 4 when k=4.
REQ-023 Clear accepted SHALL enter CLEAR for exactly 4 cycles, writing zero to addresses 0,1,2,3 in order with mem_write_enable=1 each cycle.
REQ-024 On completing CLEAR, wr_ptr=0, lap_count=0, mem_read_address=0, FSM SHALL return to IDLE.
REQ-025 mem_data_in SHALL be 0 in every state except WRITE.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately force state=IDLE, wr_ptr=0, lap_count=0, full=0, busy=0, mem_write_enable=0, mem_write_address=0, mem_data_in=0, mem_read_address=0, capture register=0, init_pending=1.
REQ-027 Reset asserted mid-WRITE or mid-CLEAR SHALL abort the operation with no further write strobes.
REQ-028 On the first rising edge after reset_n deasserts, with init_pending=1, the block SHALL enter CLEAR, perform the full 4-cycle erase, and clear init_pending; requests during this sequence SHALL be dropped.

Configuration
REQ-029 Macro LAP_OVERWRITE_EN: when defined, save with full=1 SHALL be accepted, overwriting the oldest lap at wr_ptr; lap_count stays 4 and wr_ptr advances.
REQ-030 Without LAP_OVERWRITE_EN, save with full=1 SHALL be dropped: no WRITE state, no write strobe, no state change.

Verification
REQ-031 Release reset, hold inputs idle -> busy=1 for 4 cycles; writes of 0 to addresses 0..3; then lap_count=0, busy=0.
REQ-032 Save with time_in=16'h0123 -> next cycle mem_write_enable=1, mem_write_address=0, mem_data_in=16'h0123; afterwards lap_count=1, mem_read_address=0.
REQ-033 Three saves, then next pulses -> mem_read_address sequence 2,0,1,2 (wraps modulo 3).
REQ-034 Five saves of 16'h0001..16'h0005 -> with macro, the fifth writes address 0 and lap_count=4; without macro, the fifth produces no strobe and lap_count=4.
REQ-035 clear_pulse and save_pulse in the same cycle -> CLEAR is taken and the save is dropped; a save_pulse during CLEAR is ignored; final lap_count=0.
REQ-036 reset_n low during the 2nd CLEAR cycle -> mem_write_enable falls immediately; after release, a fresh 4-cycle clear starts at address 0.
